// File: rtl/eval_word_arbiter.sv
// rtl/eval_word_arbiter.sv - two-requester burst arbiter onto one registered word channel
module eval_word_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req0_last,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_data,
   input  logic             req1_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   output logic             out_last,
   output logic [1:0]       grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t state;
   state_t next_state;
   logic   pointer;
   logic   slot_free;
   logic   accept0;
   logic   accept1;

   // The output register can take a new beat when empty or being drained this cycle.
   assign slot_free = !out_valid || out_ready;

   // Only the burst owner sees ready; IDLE always spends one cycle arbitrating.
   assign req0_ready = (state == BUSY0) && slot_free;
   assign req1_ready = (state == BUSY1) && slot_free;
   assign accept0    = req0_valid && req0_ready;
   assign accept1    = req1_valid && req1_ready;
   assign grant      = {state == BUSY1, state == BUSY0};

   // State register: ownership held until the owner's last beat is accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: round-robin pointer breaks ties in IDLE; bursts are never preempted.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req0_valid && req1_valid) begin
               next_state = pointer ? BUSY1 : BUSY0;
            end else if (req0_valid) begin
               next_state = BUSY0;
            end else if (req1_valid) begin
               next_state = BUSY1;
            end
         end
         BUSY0: begin
            if (accept0 && req0_last) begin
               next_state = IDLE;
            end
         end
         BUSY1: begin
            if (accept1 && req1_last) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Pointer favours the requester that did not just finish a burst.
   always_ff @(posedge clock) begin
      if (reset) begin
         pointer <= 1'b0;
      end else if (accept0 && req0_last) begin
         pointer <= 1'b1;
      end else if (accept1 && req1_last) begin
         pointer <= 1'b0;
      end
   end

   // Output register: load on accept, otherwise drop valid once consumed; payload holds.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept0) begin
         out_valid <= 1'b1;
         out_data  <= req0_data;
         out_src   <= 1'b0;
         out_last  <= req0_last;
      end else if (accept1) begin
         out_valid <= 1'b1;
         out_data  <= req1_data;
         out_src   <= 1'b1;
         out_last  <= req1_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_eval_word_arbiter.sv
// tb/tb_eval_word_arbiter.sv - directed self-checking bench for eval_word_arbiter
module tb_eval_word_arbiter;

   localparam int WIDTH = 32;

   logic             clock;
   logic             reset;
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_data;
   logic             req0_last;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_data;
   logic             req1_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_src;
   logic             out_last;
   logic [1:0]       grant;

   int check_count = 0;
   int pass_count  = 0;

   eval_word_arbiter #(.WIDTH(WIDTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req0_last  (req0_last),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .req1_last  (req1_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_last   (out_last),
      .grant      (grant)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] data, input logic src, input logic last);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"},  64'(out_data),  64'(data));
      check({tag, "_src"},   64'(out_src),   64'(src));
      check({tag, "_last"},  64'(out_last),  64'(last));
   endtask

   initial begin
      reset      = 1'b1;
      req0_valid = 1'b0;
      req0_data  = '0;
      req0_last  = 1'b0;
      req1_valid = 1'b0;
      req1_data  = '0;
      req1_last  = 1'b0;
      out_ready  = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_grant",  64'(grant),      64'd0);
      check("rst_valid",  64'(out_valid),  64'd0);
      check("rst_data",   64'(out_data),   64'd0);
      check("rst_src",    64'(out_src),    64'd0);
      check("rst_last",   64'(out_last),   64'd0);
      check("rst_ready0", 64'(req0_ready), 64'd0);
      check("rst_ready1", 64'(req1_ready), 64'd0);

      // Single beat from requester 0
      reset      = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 32'hA5A5A5A5;
      req0_last  = 1'b1;
      #1;
      check("single_idle_ready0", 64'(req0_ready), 64'd0);
      tick();
      check("single_grant_c1", 64'(grant), 64'd1);
      check("single_ready_c1", 64'(req0_ready), 64'd1);
      tick();
      req0_valid = 1'b0;
      check_out("single_c2", 32'hA5A5A5A5, 1'b0, 1'b1);
      check("single_grant_c2", 64'(grant), 64'd0);
      tick();
      check("single_drain_valid", 64'(out_valid), 64'd0);
      check("single_drain_hold",  64'(out_data),  64'hA5A5A5A5);

      // Alternating contention from reset
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 32'h10;
      req0_last  = 1'b1;
      req1_valid = 1'b1;
      req1_data  = 32'h20;
      req1_last  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rr_gap_valid", 64'(out_valid), 64'd0);
         tick();
         check_out("rr_beat", (k % 2 == 0) ? 32'h10 : 32'h20, 1'(k % 2), 1'b1);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      tick();

      // Four-beat burst from requester 1 while requester 0 waits
      req1_valid = 1'b1;
      req1_data  = 32'h1;
      req1_last  = 1'b0;
      tick();
      req0_valid = 1'b1;
      req0_data  = 32'h55;
      req0_last  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         req1_data = 32'(i);
         req1_last = (i == 4);
         #1;
         check("burst_ready1", 64'(req1_ready), 64'd1);
         check("burst_ready0", 64'(req0_ready), 64'd0);
         check("burst_grant",  64'(grant),      64'd2);
         tick();
         check_out("burst_beat", 32'(i), 1'b1, (i == 4));
      end
      req1_valid = 1'b0;
      check("burst_end_grant", 64'(grant), 64'd0);
      tick();
      check("burst_next_grant", 64'(grant), 64'd1);
      tick();
      req0_valid = 1'b0;
      check_out("burst_next_beat", 32'h55, 1'b0, 1'b1);
      tick();

      // Backpressure mid-burst
      req0_valid = 1'b1;
      req0_data  = 32'h100;
      req0_last  = 1'b0;
      tick();
      tick();
      check_out("bp_b0", 32'h100, 1'b0, 1'b0);
      req0_data = 32'h101;
      tick();
      check_out("bp_b1", 32'h101, 1'b0, 1'b0);
      out_ready = 1'b0;
      req0_data = 32'h102;
      for (int s = 0; s < 3; s++) begin
         #1;
         check("bp_stall_ready", 64'(req0_ready), 64'd0);
         tick();
         check_out("bp_stall_hold", 32'h101, 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_resume_ready", 64'(req0_ready), 64'd1);
      tick();
      check_out("bp_b2", 32'h102, 1'b0, 1'b0);
      req0_data = 32'h103;
      req0_last = 1'b1;
      tick();
      check_out("bp_b3", 32'h103, 1'b0, 1'b1);
      req0_valid = 1'b0;
      tick();
      check("bp_drain_valid", 64'(out_valid), 64'd0);

      // Owner pauses mid-burst, other requester waits
      req1_valid = 1'b1;
      req1_data  = 32'h200;
      req1_last  = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 32'h300;
      req0_last  = 1'b1;
      tick();
      check("pause_grant", 64'(grant), 64'd2);
      tick();
      check_out("pause_b0", 32'h200, 1'b1, 1'b0);
      req1_valid = 1'b0;
      for (int s = 0; s < 2; s++) begin
         #1;
         check("pause_ready0", 64'(req0_ready), 64'd0);
         check("pause_grant_held", 64'(grant), 64'd2);
         tick();
         check("pause_out_valid", 64'(out_valid), 64'd0);
      end
      req1_valid = 1'b1;
      req1_data  = 32'h201;
      req1_last  = 1'b1;
      tick();
      check_out("pause_b1", 32'h201, 1'b1, 1'b1);
      req1_valid = 1'b0;
      tick();
      check("pause_next_grant", 64'(grant), 64'd1);
      tick();
      req0_valid = 1'b0;
      check_out("pause_other", 32'h300, 1'b0, 1'b1);
      tick();

      // Reset with a beat held in BUSY0 and an accept pending
      req0_valid = 1'b1;
      req0_data  = 32'h400;
      req0_last  = 1'b0;
      tick();
      tick();
      check_out("mrst_pre", 32'h400, 1'b0, 1'b0);
      req0_data = 32'h401;
      reset     = 1'b1;
      tick();
      check("mrst_valid", 64'(out_valid), 64'd0);
      check("mrst_grant", 64'(grant),     64'd0);
      check("mrst_data",  64'(out_data),  64'd0);
      reset      = 1'b0;
      req0_data  = 32'h500;
      req0_last  = 1'b1;
      req1_valid = 1'b1;
      req1_data  = 32'h600;
      req1_last  = 1'b1;
      #1;
      check("mrst_idle_valid", 64'(out_valid), 64'd0);
      tick();
      check("mrst_contend_grant", 64'(grant), 64'd1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check_out("mrst_beat", 32'h500, 1'b0, 1'b1);
      tick();

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
